// File: rtl/keypad_scan_rx.sv
// keypad_scan_rx: 4x4 keypad column scanner with debounced single-strobe key reporting.
// Define KEYPAD_HEX_MAP_EN to report hex keypad labels instead of raw {row, col} codes.
module keypad_scan_rx #(
  parameter int SCAN_BITS    = 17,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  localparam logic [7:0] DC = 8'(DEBOUNCE_CNT);
  state_t state, state_n;
  logic [3:0] s1, rows_s, code_n;
  logic [SCAN_BITS-1:0] dwell;
  logic [1:0] col_idx, row_idx, cand_row, cand_row_n;
  logic [7:0] stable, stable_n, stable_inc;
  logic sample, valid, accept, advance, held_n;
  assign sample = &dwell;
  // Multi-key patterns are treated as idle so ghosted keys are never reported.
  assign valid = $countones(~rows_s) == 1;
  assign row_idx = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;
  assign stable_inc = (stable == 8'hFF) ? stable : stable + 8'd1;
  assign col_out = ~(4'b0001 << col_idx);
`ifdef KEYPAD_HEX_MAP_EN
  localparam logic [63:0] HEX = 64'hDEF0_C987_B654_A321;
  assign code_n = HEX[{cand_row_n, col_idx, 2'b00} +: 4];
`else
  assign code_n = {cand_row_n, col_idx};
`endif
  always_comb begin
    state_n = state;
    stable_n = stable;
    cand_row_n = cand_row;
    accept = 1'b0;
    advance = 1'b0;
    held_n = key_held;
    if (sample) begin
      if (state == SCAN) begin
        if (valid) begin
          cand_row_n = row_idx;
          stable_n = 8'd1;
          state_n = DEBOUNCE;
          if (DC <= 8'd1) begin
            accept = 1'b1;
            stable_n = 8'd0;
            state_n = PRESSED;
            held_n = 1'b1;
          end
        end else advance = 1'b1;
      end else if (state == DEBOUNCE) begin
        if (valid && row_idx == cand_row) begin
          stable_n = stable_inc;
          if (stable_inc >= DC) begin
            accept = 1'b1;
            stable_n = 8'd0;
            state_n = PRESSED;
            held_n = 1'b1;
          end
        end else begin
          stable_n = 8'd0;
          state_n = SCAN;
          advance = 1'b1;
        end
      end else begin
        stable_n = valid ? 8'd0 : stable_inc;
        if (!valid && stable_inc >= DC) begin
          stable_n = 8'd0;
          state_n = SCAN;
          held_n = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 4'hF;
      rows_s <= 4'hF;
      dwell <= '0;
      col_idx <= '0;
      state <= SCAN;
      stable <= '0;
      cand_row <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      s1 <= row_in;
      rows_s <= s1;
      dwell <= dwell + 1'b1;
      col_idx <= col_idx + 2'(advance);
      state <= state_n;
      stable <= stable_n;
      cand_row <= cand_row_n;
      key_valid <= accept;
      key_held <= held_n;
      if (accept) key_code <= code_n;
    end
  end
endmodule

// File: tb/tb_keypad_scan_rx.sv
// tb_keypad_scan_rx: keypad scanner bench with a per-sample reference model and a keypad contact model.
module tb_keypad_scan_rx;
  localparam int DC = 3;
  localparam int DWELL = 4;
  localparam int SCANNING = 0, CONFIRMING = 1, HOLDING = 2;
  localparam logic [3:0] HEX [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                                        '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'h0, 4'hF, 4'hE, 4'hD}};
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] row_in, col_out, key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  int nvec = 0, nerr = 0, pulses = 0;
  int m_col = 0, m_phase = SCANNING, m_streak = 0, m_k = 0, m_cand = 0;
  logic [3:0] m_code = '0, d1 = 4'hF, d2 = 4'hF;
  logic m_valid = 1'b0, m_held = 1'b0;

  keypad_scan_rx #(.SCAN_BITS(2), .DEBOUNCE_CNT(DC)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held));

  always #5 clk = ~clk;

  // A closed contact at (r, c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic logic [3:0] map(int r, int c);
`ifdef KEYPAD_HEX_MAP_EN
    return HEX[r][c];
`else
    return 4'(r * 4 + c);
`endif
  endfunction

  function automatic logic [3:0] rows_for(logic [15:0] k, int c);
    logic [3:0] v = 4'hF;
    for (int r = 0; r < 4; r++) if (k[r*4+c]) v[r] = 1'b0;
    return v;
  endfunction

  function automatic int low_row(logic [3:0] p);
    int n = 0, idx = -1;
    for (int r = 0; r < 4; r++) if (!p[r]) begin n++; idx = r; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic accept_key();
    m_code = map(m_cand, m_col);
    m_valid = 1'b1;
    m_held = 1'b1;
    m_streak = 0;
    m_phase = HOLDING;
  endtask

  // One reference step per clock edge; a sample is taken every DWELL-th cycle after reset.
  task automatic model_step();
    logic [3:0] pat;
    int r;
    if (reset) begin
      m_col = 0; m_code = '0; m_valid = 1'b0; m_held = 1'b0;
      m_phase = SCANNING; m_streak = 0; m_k = 0; d1 = 4'hF; d2 = 4'hF;
      return;
    end
    pat = d2;
    d2 = d1;
    d1 = rows_for(keys, m_col);
    m_valid = 1'b0;
    if (m_k % DWELL == DWELL - 1) begin
      r = low_row(pat);
      if (m_phase == SCANNING) begin
        if (r >= 0) begin
          m_cand = r; m_streak = 1; m_phase = CONFIRMING;
          if (m_streak >= DC) accept_key();
        end else m_col = (m_col + 1) % 4;
      end else if (m_phase == CONFIRMING) begin
        if (r == m_cand) begin
          m_streak++;
          if (m_streak >= DC) accept_key();
        end else begin
          m_phase = SCANNING; m_streak = 0; m_col = (m_col + 1) % 4;
        end
      end else begin
        m_streak = (r < 0) ? m_streak + 1 : 0;
        if (m_streak >= DC) begin m_phase = SCANNING; m_streak = 0; m_held = 1'b0; end
      end
    end
    m_k++;
  endtask

  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0] ec;
    @(posedge clk);
    model_step();
    @(negedge clk);
    ec = 4'hF;
    ec[m_col] = 1'b0;
    cmp("col_out", 8'(col_out), 8'(ec));
    cmp("key_code", 8'(key_code), 8'(m_code));
    cmp("key_valid", 8'(key_valid), 8'(m_valid));
    cmp("key_held", 8'(key_held), 8'(m_held));
    if (key_valid) pulses++;
  endtask

  typedef struct {
    logic [15:0] keys;
    int cycles;
    int pulses;
    logic [3:0] code;
    logic held;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'h0000, 100, 0, 4'h0, 1'b0};
    tbl[1] = '{16'h0010, 60, 1, map(1, 0), 1'b1};
    tbl[2] = '{16'h0000, 16, 0, map(1, 0), 1'b0};
    tbl[3] = '{16'h4004, 80, 0, map(1, 0), 1'b0};
    tbl[4] = '{16'h0004, 60, 1, map(0, 2), 1'b1};
    tbl[5] = '{16'h0000, 40, 0, map(0, 2), 1'b0};
    repeat (3) tick();
    cmp("rst_col", 8'(col_out), 8'h0E);
    cmp("rst_code", 8'(key_code), 8'h00);
    cmp("rst_valid", 8'(key_valid), 8'h00);
    cmp("rst_held", 8'(key_held), 8'h00);
    reset = 1'b0;
    foreach (tbl[i]) begin
      keys = tbl[i].keys;
      pulses = 0;
      repeat (tbl[i].cycles) tick();
      cmp($sformatf("tbl%0d_pulses", i), 8'(pulses), 8'(tbl[i].pulses));
      cmp($sformatf("tbl%0d_code", i), 8'(key_code), 8'(tbl[i].code));
      cmp($sformatf("tbl%0d_held", i), 8'(key_held), 8'(tbl[i].held));
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 16'h0010 : 16'h0000;
      repeat (DWELL) tick();
    end
    cmp("bounce_pulses", 8'(pulses), 8'h00);
    keys = 16'h0010;
    repeat (60) tick();
    cmp("bounce_settle_pulses", 8'(pulses), 8'h01);
    cmp("bounce_code", 8'(key_code), 8'(map(1, 0)));
    keys = 16'h0000;
    repeat (40) tick();
    pulses = 0;
    keys = 16'h0010;
    begin
      int n = 0;
      while (!(m_phase == CONFIRMING && m_streak == DC - 1 && m_k % DWELL == DWELL - 2) && n < 100) begin
        tick();
        n++;
      end
      cmp("middeb_reached", 8'(n < 100), 8'h01);
    end
    reset = 1'b1;
    tick();
    cmp("middeb_col", 8'(col_out), 8'h0E);
    cmp("middeb_code", 8'(key_code), 8'h00);
    cmp("middeb_valid", 8'(key_valid), 8'h00);
    cmp("middeb_held", 8'(key_held), 8'h00);
    reset = 1'b0;
    keys = 16'h0000;
    repeat (20) tick();
    cmp("middeb_pulses", 8'(pulses), 8'h00);
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 2);
      keys = '0;
      if (kind >= 1) keys[$urandom_range(0, 15)] = 1'b1;
      if (kind == 2) keys[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(4, 50)) tick();
    end
    keys = '0;
    repeat (40) tick();
    cmp("final_held", 8'(key_held), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
